// File: rtl/change_dispenser_pkg.sv
// Shared constants for the change dispenser: default widths, coin denominations and FSM encoding.
package change_dispenser_pkg;

    localparam int VAL_W_DEF      = 7;
    localparam int CNT_W_DEF      = 6;
    localparam int INIT_STOCK_DEF = 20;

    localparam int D0_DEF = 10;
    localparam int D1_DEF = 5;
    localparam int D2_DEF = 2;
    localparam int D3_DEF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } disp_state_t;

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Four saturating coin stock counters; refill from outside, decrement on each coin handed to the hopper.
module coin_stock #(
    parameter int CNT_W      = 6,
    parameter int INIT_STOCK = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_refill,
    input  logic [1:0]       i_refill_sel,
    input  logic [CNT_W-1:0] i_refill_count,
    input  logic             i_dec,
    input  logic [1:0]       i_dec_sel,
    output logic [3:0]       o_stock_empty
);

    localparam logic [CNT_W:0] MAX_CNT = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] stock    [4];
    logic [CNT_W-1:0] stock_nx [4];
    logic [CNT_W:0]   sum      [4];

    // A refill and a decrement on the same counter combine before saturating.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum[k] = {1'b0, stock[k]};
            if (i_refill && (i_refill_sel == 2'(k)))
                sum[k] = sum[k] + {1'b0, i_refill_count};
            if (i_dec && (i_dec_sel == 2'(k)))
                sum[k] = sum[k] - 1'b1;
            stock_nx[k] = (sum[k] > MAX_CNT) ? MAX_CNT[CNT_W-1:0] : sum[k][CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!i_rst_n)
                stock[k] <= CNT_W'(INIT_STOCK);
            else
                stock[k] <= stock_nx[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            o_stock_empty[k] = (stock[k] == '0);
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout FSM: picks the largest in-stock coin that fits and hands it to the hopper.
// state  | meaning
// IDLE   | waiting for i_load
// SELECT | choose next coin or finish
// ISSUE  | coin offered, waiting for hopper ready
// DONE   | one-cycle completion pulse
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int VAL_W      = VAL_W_DEF,
    parameter int D0         = D0_DEF,
    parameter int D1         = D1_DEF,
    parameter int D2         = D2_DEF,
    parameter int D3         = D3_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int INIT_STOCK = INIT_STOCK_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [VAL_W-1:0] i_change_value,
    output logic             o_busy,
    output logic             o_coin_valid,
    output logic [1:0]       o_coin_sel,
    input  logic             i_coin_ready,
    output logic             o_done,
    output logic [VAL_W-1:0] o_shortfall,
    input  logic             i_refill,
    input  logic [1:0]       i_refill_sel,
    input  logic [CNT_W-1:0] i_refill_count,
    output logic [3:0]       o_stock_empty,
    output logic [1:0]       o_state
);

    localparam logic [VAL_W-1:0] DEN [4] = '{VAL_W'(D0), VAL_W'(D1), VAL_W'(D2), VAL_W'(D3)};

    disp_state_t      state, state_nx;
    logic [VAL_W-1:0] remaining;
    logic [VAL_W-1:0] shortfall;
    logic [1:0]       coin_sel;
    logic             handshake;
    logic             found;
    logic [1:0]       pick;

    assign handshake = (state == ISSUE) && i_coin_ready;

    // Scanning from smallest to largest leaves the lowest fitting index in pick.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if ((DEN[k] <= remaining) && !o_stock_empty[k]) begin
                found = 1'b1;
                pick  = 2'(k);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_load) state_nx = (i_change_value == '0) ? DONE : SELECT;
            SELECT:  state_nx = found ? ISSUE : DONE;
            ISSUE:   if (i_coin_ready) state_nx = SELECT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            shortfall <= '0;
            coin_sel  <= 2'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (i_load) begin
                        remaining <= i_change_value;
                        shortfall <= '0;
                    end
                end
                SELECT: begin
                    if (found) coin_sel  <= pick;
                    else       shortfall <= remaining;
                end
                ISSUE: begin
                    if (i_coin_ready) remaining <= remaining - DEN[coin_sel];
                end
                default: ;
            endcase
        end
    end

    coin_stock #(
        .CNT_W      (CNT_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_coin_stock (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_refill       (i_refill),
        .i_refill_sel   (i_refill_sel),
        .i_refill_count (i_refill_count),
        .i_dec          (handshake),
        .i_dec_sel      (coin_sel),
        .o_stock_empty  (o_stock_empty)
    );

    assign o_busy       = (state != IDLE);
    assign o_coin_valid = (state == ISSUE);
    assign o_coin_sel   = coin_sel;
    assign o_done       = (state == DONE);
    assign o_shortfall  = shortfall;
    assign o_state      = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default-stock instance plus a stock-of-one instance.
module tb_change_dispenser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       load, ready, refill, busy, valid, done;
    logic [6:0] value, shortfall;
    logic [1:0] sel, refill_sel, state;
    logic [5:0] refill_count;
    logic [3:0] empty;

    logic       load1, ready1, refill1, busy1, valid1, done1;
    logic [6:0] value1, shortfall1;
    logic [1:0] sel1, refill_sel1, state1;
    logic [5:0] refill_count1;
    logic [3:0] empty1;

    change_dispenser dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_change_value(value),
        .o_busy(busy), .o_coin_valid(valid), .o_coin_sel(sel), .i_coin_ready(ready),
        .o_done(done), .o_shortfall(shortfall), .i_refill(refill), .i_refill_sel(refill_sel),
        .i_refill_count(refill_count), .o_stock_empty(empty), .o_state(state)
    );

    change_dispenser #(.INIT_STOCK(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load1), .i_change_value(value1),
        .o_busy(busy1), .o_coin_valid(valid1), .o_coin_sel(sel1), .i_coin_ready(ready1),
        .o_done(done1), .o_shortfall(shortfall1), .i_refill(refill1), .i_refill_sel(refill_sel1),
        .i_refill_count(refill_count1), .o_stock_empty(empty1), .o_state(state1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] coins[$];
    int got_done;
    int wait_cycles;
    int tens;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit which, input logic [6:0] v);
        coins.delete();
        if (which) begin load1 = 1'b1; value1 = v; end
        else       begin load  = 1'b1; value  = v; end
        tick();
        load  = 1'b0;
        load1 = 1'b0;
    endtask

    // Records every coin accepted by the hopper until o_done, then steps back to IDLE.
    task automatic collect(input bit which);
        got_done = 0;
        wait_cycles = 0;
        for (int c = 0; c < 300; c++) begin
            if (which ? done1 : done) begin
                got_done = 1;
                break;
            end
            if (which ? (valid1 && ready1) : (valid && ready))
                coins.push_back(which ? sel1 : sel);
            tick();
            wait_cycles++;
        end
        check("done_seen", got_done, 1);
        tick();
    endtask

    task automatic check_coins(input string tag, input int n, input logic [7:0] exp_seq);
        logic [7:0] seq;
        seq = exp_seq;
        check({tag, "_count"}, coins.size(), n);
        for (int i = 0; i < n && i < coins.size(); i++)
            check({tag, "_sel"}, coins[i], seq[2*i +: 2]);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 0; value = 0; ready = 1; refill = 0; refill_sel = 0; refill_count = 0;
        load1 = 0; value1 = 0; ready1 = 1; refill1 = 0; refill_sel1 = 0; refill_count1 = 0;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_shortfall", shortfall, 0);
        check("rst_empty", empty, 4'b0000);
        check("rst_empty1", empty1, 4'b0000);
        rst_n = 1'b1;
        tick();

        // 30 -> three 10s, with load-to-valid latency of two cycles
        start(0, 7'd30);
        check("t1_state_select", state, 1);
        check("t1_busy", busy, 1);
        check("t1_valid_early", valid, 0);
        tick();
        check("t1_valid", valid, 1);
        check("t1_first_sel", sel, 0);
        collect(0);
        check_coins("t1", 3, 8'b00_00_00_00);
        check("t1_shortfall", shortfall, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_done", done, 0);
        check("t1_empty", empty, 4'b0000);

        // 18 -> 10,5,2,1
        start(0, 7'd18);
        collect(0);
        check_coins("t2", 4, 8'b11_10_01_00);
        check("t2_shortfall", shortfall, 0);

        // 0 -> straight to DONE
        start(0, 7'd0);
        check("t3_state_done", state, 3);
        collect(0);
        check("t3_latency", wait_cycles, 0);
        check("t3_coins", coins.size(), 0);
        check("t3_shortfall", shortfall, 0);
        check("t3_busy", busy, 0);

        // Backpressure: 7 -> 5,2 with ready held low and a stray load
        ready = 1'b0;
        start(0, 7'd7);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_valid_hold", valid, 1);
            check("t5_sel_hold", sel, 1);
            check("t5_state_hold", state, 2);
            if (i == 1) begin load = 1'b1; value = 7'd50; end
            tick();
            load = 1'b0;
        end
        ready = 1'b1;
        collect(0);
        check_coins("t5", 2, 8'b00_00_10_01);
        check("t5_shortfall", shortfall, 0);
        check("t5_idle", state, 0);

        // Stock of one: 4 -> 2,1, shortfall 1
        start(1, 7'd4);
        collect(1);
        check_coins("t4", 2, 8'b00_00_11_10);
        check("t4_shortfall", shortfall1, 1);
        check("t4_empty", empty1, 4'b1100);

        // Refill five 1-coins, then pay 3 from them
        refill1 = 1'b1; refill_sel1 = 2'd3; refill_count1 = 6'd5;
        tick();
        refill1 = 1'b0;
        check("t6_refill_empty", empty1, 4'b0100);
        start(1, 7'd3);
        collect(1);
        check_coins("t6", 3, 8'b00_11_11_11);
        check("t6_shortfall", shortfall1, 0);

        // Reset while a coin is offered
        ready = 1'b0;
        start(0, 7'd20);
        tick();
        check("t7_valid_pre", valid, 1);
        rst_n = 1'b0;
        tick();
        check("t7_valid_rst", valid, 0);
        check("t7_state_rst", state, 0);
        check("t7_done_rst", done, 0);
        rst_n = 1'b1;
        tick();
        check("t7_done_after", done, 0);
        check("t7_busy_after", busy, 0);
        check("t7_empty1_restored", empty1, 4'b0000);

        // Full stock check: two 127 payouts use 12 then exactly 8 tens
        ready = 1'b1;
        start(0, 7'd127);
        collect(0);
        tens = 0;
        foreach (coins[i]) if (coins[i] == 2'd0) tens++;
        check("t8_tens_first", tens, 12);
        check("t8_count_first", coins.size(), 14);
        check("t8_shortfall_first", shortfall, 0);
        start(0, 7'd127);
        collect(0);
        tens = 0;
        foreach (coins[i]) if (coins[i] == 2'd0) tens++;
        check("t8_tens_second", tens, 8);
        check("t8_count_second", coins.size(), 18);
        check("t8_shortfall_second", shortfall, 0);
        check("t8_empty", empty, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
